// File: rtl/iis_fifo_wr_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iis_fifo_wr_arbiter_if : requester bundle plus shared FIFO write port
// rev 1.0
// ---------------------------------------------------------------------------
interface iis_fifo_wr_arbiter_if #(
   parameter int data_width = 16,
   parameter int num_req    = 2
);
   logic [num_req-1:0]            req_valid;
   logic [num_req*data_width-1:0] req_data;
   logic [num_req-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [data_width-1:0]         fifo_din;

   // master: producers and FIFO side; slave: the arbiter
   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_din
   );
   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_din
   );
endinterface
`default_nettype wire

// File: rtl/iis_fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iis_fifo_wr_arbiter : round-robin FIFO write arbiter with stereo L/R pairing
// rev 1.0
// ---------------------------------------------------------------------------
module iis_fifo_wr_arbiter #(
   parameter int data_width   = 16,
   parameter int num_req      = 2,
   parameter int pair_timeout = 64
) (
   input  wire logic                       rst,
   input  wire logic                       wr_clk,
   iis_fifo_wr_arbiter_if.slave            bus,
   input  wire logic                       pair_mode,
   input  wire logic                       clr_stats,
   output logic [$clog2(num_req)-1:0]      grant_id,
   output logic [15:0]                     stall_cnt,
   output logic                            pair_err
);
   localparam int ID_W = $clog2(num_req);

   typedef enum logic [0:0] {
      FREE   = 1'b0,
      WAIT_R = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [15:0]       wait_cnt_q, wait_cnt_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic              pair_err_q, pair_err_d;

   logic [num_req-1:0] eligible;
   logic [num_req-1:0] cand;
   logic               grant_vld;
   logic [ID_W-1:0]    grant_idx;
   logic               timeout;

   always_comb begin
      int j;
      j = 0;
      eligible = '1;
      if (state_q == WAIT_R) begin
         eligible    = '0;
         eligible[1] = 1'b1;
      end else if (pair_mode) begin
         eligible[1] = 1'b0;
      end
      cand      = bus.req_valid & eligible;
      grant_vld = 1'b0;
      grant_idx = '0;
      // scan downward so the candidate closest to the pointer is the last writer
      for (int k = num_req - 1; k >= 0; k--) begin
         j = int'(ptr_q) + k;
         if (j >= num_req) j = j - num_req;
         if (cand[j]) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(j);
         end
      end
      if (!rst || bus.fifo_full) grant_vld = 1'b0;
   end

   assign bus.req_ready  = grant_vld ? ({{(num_req-1){1'b0}}, 1'b1} << grant_idx) : '0;
   assign bus.fifo_wr_en = |(bus.req_valid & bus.req_ready);
   assign bus.fifo_din   = bus.req_data[grant_idx*data_width +: data_width];

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_id_d  = grant_id_q;
      wait_cnt_d  = wait_cnt_q;
      stall_cnt_d = stall_cnt_q;
      pair_err_d  = pair_err_q;
      timeout     = 1'b0;

      if (grant_vld) begin
         ptr_d      = (grant_idx == ID_W'(num_req - 1)) ? '0 : grant_idx + ID_W'(1);
         grant_id_d = grant_idx;
      end

      case (state_q)
         FREE: begin
            if (pair_mode && grant_vld && grant_idx == '0) begin
               state_d    = WAIT_R;
               wait_cnt_d = '0;
            end
         end
         WAIT_R: begin
            // only requester 1 is eligible here, so any grant closes the pair
            if (grant_vld || !pair_mode) begin
               state_d = FREE;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
               if ({1'b0, wait_cnt_q} + 17'd1 >= 17'(pair_timeout)) begin
                  state_d = FREE;
                  timeout = 1'b1;
               end
            end
         end
         default: state_d = FREE;
      endcase

      if (clr_stats) begin
         stall_cnt_d = '0;
         pair_err_d  = 1'b0;
      end else begin
         if (bus.fifo_full && (|bus.req_valid) && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
         if (timeout)
            pair_err_d = 1'b1;
      end
   end

   always_ff @(posedge wr_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FREE;
         ptr_q       <= '0;
         grant_id_q  <= '0;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         pair_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_id_q  <= grant_id_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         pair_err_q  <= pair_err_d;
      end
   end

   assign grant_id  = grant_id_q;
   assign stall_cnt = stall_cnt_q;
   assign pair_err  = pair_err_q;
endmodule
`default_nettype wire

// File: tb/tb_iis_fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iis_fifo_wr_arbiter : directed and randomized bench with behavioural model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_iis_fifo_wr_arbiter;
   localparam int DW = 16;
   localparam int NR = 3;
   localparam int TO = 8;

   logic          wr_clk = 1'b0;
   logic          rst = 1'b0;
   logic          pair_mode = 1'b0;
   logic          clr_stats = 1'b0;
   logic [1:0]    grant_id;
   logic [15:0]   stall_cnt;
   logic          pair_err;
   logic [DW-1:0] dat [NR];
   int            checks = 0;
   int            failures = 0;

   // behavioural model state
   int m_ptr, m_gid, m_stall, m_cnt;
   bit m_wait, m_perr;

   iis_fifo_wr_arbiter_if #(.data_width(DW), .num_req(NR)) bus ();

   iis_fifo_wr_arbiter #(
      .data_width(DW), .num_req(NR), .pair_timeout(TO)
   ) dut (
      .rst(rst), .wr_clk(wr_clk), .bus(bus),
      .pair_mode(pair_mode), .clr_stats(clr_stats),
      .grant_id(grant_id), .stall_cnt(stall_cnt), .pair_err(pair_err)
   );

   always #5 wr_clk = ~wr_clk;

   function automatic void m_reset();
      m_ptr = 0; m_gid = 0; m_stall = 0; m_cnt = 0; m_wait = 0; m_perr = 0;
   endfunction

   // first valid, eligible requester at or after the pointer; -1 for none
   function automatic int m_grant();
      int i;
      bit elig;
      if (!rst || bus.fifo_full) return -1;
      for (int k = 0; k < NR; k++) begin
         i = (m_ptr + k) % NR;
         elig = m_wait ? (i == 1) : !(pair_mode && i == 1);
         if (elig && bus.req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic void m_step();
      int g;
      bit tmo;
      if (!rst) begin
         m_reset();
         return;
      end
      g = m_grant();
      tmo = 0;
      if (m_wait) begin
         if (g == 1 || !pair_mode) m_wait = 0;
         else begin
            m_cnt++;
            if (m_cnt >= TO) begin m_wait = 0; tmo = 1; end
         end
      end else if (pair_mode && g == 0) begin
         m_wait = 1; m_cnt = 0;
      end
      if (g >= 0) begin m_ptr = (g + 1) % NR; m_gid = g; end
      if (clr_stats) begin
         m_stall = 0; m_perr = 0;
      end else begin
         if (bus.fifo_full && (|bus.req_valid) && m_stall < 65535) m_stall++;
         if (tmo) m_perr = 1;
      end
   endfunction

   task automatic tick();
      m_step();
      @(posedge wr_clk);
      @(negedge wr_clk);
   endtask

   task automatic drive(input logic [NR-1:0] v);
      bus.req_valid = v;
      for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = dat[i];
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      m_reset();
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      drive(3'b111);
      bus.fifo_full = 1'b0;
      tick();
      #1;
      checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
      checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.fifo_wr_en); end
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
      checks++; if (pair_err !== 1'b0) begin failures++; $display("FAIL reset_pair_err got=%b exp=0", pair_err); end
      tick();
      rst = 1'b1;
   endtask

   task automatic test_round_robin();
      int e;
      do_reset();
      pair_mode = 1'b0;
      bus.fifo_full = 1'b0;
      dat[0] = 16'hA0A0; dat[1] = 16'hB1B1; dat[2] = 16'hC2C2;
      drive(3'b111);
      for (int k = 0; k < 6; k++) begin
         #1;
         e = k % 3;
         checks++; if (bus.req_ready !== (3'b001 << e)) begin failures++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus.req_ready, 3'b001 << e); end
         checks++; if (bus.fifo_wr_en !== 1'b1) begin failures++; $display("FAIL rr_wr_en k=%0d got=%b exp=1", k, bus.fifo_wr_en); end
         checks++; if (bus.fifo_din !== dat[e]) begin failures++; $display("FAIL rr_din k=%0d got=%h exp=%h", k, bus.fifo_din, dat[e]); end
         if (k > 0) begin
            checks++; if (grant_id !== 2'((k - 1) % 3)) begin failures++; $display("FAIL rr_grant_id k=%0d got=%0d exp=%0d", k, grant_id, (k - 1) % 3); end
         end
         tick();
      end
   endtask

   task automatic test_back_pressure();
      do_reset();
      pair_mode = 1'b0;
      drive(3'b011);
      bus.fifo_full = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         checks++; if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 3'b000) begin failures++; $display("FAIL bp_blocked k=%0d got=%b/%b exp=0/000", k, bus.fifo_wr_en, bus.req_ready); end
         tick();
      end
      bus.fifo_full = 1'b0;
      #1;
      checks++; if (stall_cnt !== 16'd10) begin failures++; $display("FAIL bp_stall got=%0d exp=10", stall_cnt); end
      checks++; if (bus.req_ready !== 3'b001 || bus.fifo_wr_en !== 1'b1) begin failures++; $display("FAIL bp_resume got=%b/%b exp=001/1", bus.req_ready, bus.fifo_wr_en); end
      tick();
      drive(3'b000);
   endtask

   task automatic test_pair_mode();
      do_reset();
      pair_mode = 1'b1;
      bus.fifo_full = 1'b0;
      drive(3'b010);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL pair_r_early k=%0d got=%b exp=000", k, bus.req_ready); end
         tick();
      end
      drive(3'b011);
      #1;
      checks++; if (bus.req_ready !== 3'b001 || bus.fifo_din !== dat[0]) begin failures++; $display("FAIL pair_left got=%b/%h exp=001/%h", bus.req_ready, bus.fifo_din, dat[0]); end
      tick();
      drive(3'b010);
      #1;
      checks++; if (bus.req_ready !== 3'b010 || bus.fifo_din !== dat[1]) begin failures++; $display("FAIL pair_right got=%b/%h exp=010/%h", bus.req_ready, bus.fifo_din, dat[1]); end
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL pair_gid_l got=%0d exp=0", grant_id); end
      tick();
      drive(3'b100);
      #1;
      checks++; if (bus.req_ready !== 3'b100) begin failures++; $display("FAIL pair_free got=%b exp=100", bus.req_ready); end
      checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL pair_gid_r got=%0d exp=1", grant_id); end
      tick();
      drive(3'b000);
   endtask

   task automatic test_timeout();
      do_reset();
      pair_mode = 1'b1;
      bus.fifo_full = 1'b0;
      drive(3'b001);
      #1;
      checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL to_left got=%b exp=001", bus.req_ready); end
      tick();
      drive(3'b100);
      for (int k = 1; k <= 8; k++) begin
         #1;
         checks++; if (bus.req_ready !== 3'b000 || pair_err !== 1'b0) begin failures++; $display("FAIL to_wait k=%0d got=%b/%b exp=000/0", k, bus.req_ready, pair_err); end
         tick();
      end
      #1;
      checks++; if (pair_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", pair_err); end
      checks++; if (bus.req_ready !== 3'b000 && bus.req_ready !== 3'b100) begin failures++; $display("FAIL to_free got=%b exp=100", bus.req_ready); end
      checks++; if (bus.req_ready !== 3'b100) begin failures++; $display("FAIL to_free2 got=%b exp=100", bus.req_ready); end
      bus.fifo_full = 1'b1;
      repeat (3) tick();
      #1;
      checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL to_stall got=%0d exp=3", stall_cnt); end
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      #1;
      checks++; if (stall_cnt !== 16'd0 || pair_err !== 1'b0) begin failures++; $display("FAIL to_clr got=%0d/%b exp=0/0", stall_cnt, pair_err); end
      bus.fifo_full = 1'b0;
      tick();
      drive(3'b000);
      do_reset();
      drive(3'b001);
      tick();
      drive(3'b000);
      repeat (7) tick();
      drive(3'b010);
      #1;
      checks++; if (bus.req_ready !== 3'b010) begin failures++; $display("FAIL to_late_r got=%b exp=010", bus.req_ready); end
      tick();
      drive(3'b001);
      #1;
      checks++; if (pair_err !== 1'b0 || grant_id !== 2'd1) begin failures++; $display("FAIL to_late_err got=%b/%0d exp=0/1", pair_err, grant_id); end
      checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL to_late_free got=%b exp=001", bus.req_ready); end
      tick();
      drive(3'b000);
   endtask

   task automatic test_reset_mid_pair();
      do_reset();
      pair_mode = 1'b1;
      bus.fifo_full = 1'b0;
      drive(3'b001);
      tick();
      drive(3'b100);
      bus.fifo_full = 1'b1;
      repeat (2) tick();
      bus.fifo_full = 1'b0;
      tick();
      #2 rst = 1'b0;
      m_reset();
      drive(3'b111);
      #1;
      checks++; if (bus.req_ready !== 3'b000 || bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL mid_rst_out got=%b/%b exp=000/0", bus.req_ready, bus.fifo_wr_en); end
      checks++; if (stall_cnt !== 16'd0 || pair_err !== 1'b0 || grant_id !== 2'd0) begin failures++; $display("FAIL mid_rst_regs got=%0d/%b/%0d exp=0/0/0", stall_cnt, pair_err, grant_id); end
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL mid_rst_first got=%b exp=001", bus.req_ready); end
      tick();
      drive(3'b000);
   endtask

   task automatic test_saturation();
      do_reset();
      pair_mode = 1'b0;
      drive(3'b001);
      bus.fifo_full = 1'b1;
      repeat (65534) tick();
      #1;
      checks++; if (stall_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt); end
      tick();
      #1;
      checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hit got=%h exp=ffff", stall_cnt); end
      tick();
      #1;
      checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
      bus.fifo_full = 1'b0;
      tick();
      drive(3'b000);
   endtask

   task automatic test_random();
      logic [NR-1:0] v;
      logic [NR-1:0] er;
      int g;
      do_reset();
      v = '0;
      for (int n = 0; n < 2500; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!v[i] && $urandom_range(0, (i == 1) ? 9 : 2) == 0) begin
               v[i] = 1'b1;
               dat[i] = DW'($urandom);
            end
         end
         drive(v);
         bus.fifo_full = ($urandom_range(0, 3) == 0);
         clr_stats = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) pair_mode = ~pair_mode;
         #1;
         g = m_grant();
         er = (g < 0) ? '0 : (NR'(1) << g);
         checks++; if (bus.req_ready !== er || bus.fifo_wr_en !== (g >= 0)) begin failures++; $display("FAIL rnd_grant n=%0d got=%b/%b exp=%b/%b", n, bus.req_ready, bus.fifo_wr_en, er, g >= 0); end
         if (g >= 0) begin
            checks++; if (bus.fifo_din !== dat[g]) begin failures++; $display("FAIL rnd_din n=%0d got=%h exp=%h", n, bus.fifo_din, dat[g]); end
         end
         checks++; if (grant_id !== 2'(m_gid) || stall_cnt !== 16'(m_stall) || pair_err !== m_perr) begin failures++; $display("FAIL rnd_regs n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n, grant_id, stall_cnt, pair_err, m_gid, m_stall, m_perr); end
         tick();
         if (g >= 0) v[g] = 1'b0;
      end
      clr_stats = 1'b0;
      drive(3'b000);
   endtask

   initial begin
      for (int i = 0; i < NR; i++) dat[i] = DW'(16'h1111 * (i + 1));
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      m_reset();
      @(negedge wr_clk);
      test_reset();
      test_round_robin();
      test_back_pressure();
      test_pair_mode();
      test_timeout();
      test_reset_mid_pair();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/iis_fifo_wr_arbiter.md
# iis_fifo_wr_arbiter

Write-side arbiter and sequencer for the IIS sample FIFO, in the wr_clk domain. Shares the FIFO write port (wr_en/din/full) between up to num_req sample producers with round-robin arbitration. Optional stereo pair mode forces strict left/right ordering (requester 0 then requester 1) with a timeout. Also keeps back-pressure statistics for software.

## Interface
- data_width, 16: sample width; must match the FIFO data width.
- num_req, 2: number of requesters, 2..8. Requesters 0/1 are the stereo L/R pair.
- pair_timeout, 64: cycles allowed in WAIT_R before the pair is abandoned, 1..65535.
- rst  in  1  reset; asynchronous, active-low.
- wr_clk  in  1  clock; FIFO write clock.
- req_valid  in  num_req  per-requester sample valid.
- req_data  in  num_req*data_width  requester i occupies bits [i*data_width +: data_width].
- req_ready  out  num_req  per-requester accept; a transfer occurs when valid && ready.
- fifo_full  in  1  FIFO full flag, write domain.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  data_width  FIFO write data.
- pair_mode  in  1  enables the stereo pairing rule; quasi-static.
- clr_stats  in  1  synchronous clear of stall_cnt and pair_err.
- grant_id  out  $clog2(num_req)  index of the last granted requester (registered).
- stall_cnt  out  16  saturating count of back-pressure cycles.
- pair_err  out  1  sticky flag: a pair timeout occurred.

## Operation
- At most one grant per cycle. No grant is issued while fifo_full=1.
- req_ready[i] is combinational and is 1 only for the granted index.
- fifo_wr_en = |(req_valid & req_ready). fifo_din = data of the granted requester, passed combinationally in the same cycle.
- Round-robin pointer: after each transfer, the pointer moves to (granted index + 1) mod num_req. The search starts at the pointer. After reset the pointer is 0.
- FSM states:
  - FREE: normal round-robin grant.
  - WAIT_R: a left sample has been written; waiting for the matching right sample.
- FREE, pair_mode=0: all requesters are eligible.
- FREE, pair_mode=1: requester 1 is not eligible. A transfer from requester 0 moves the FSM to WAIT_R.
- WAIT_R: only requester 1 is eligible.
  - A requester-1 transfer returns the FSM to FREE.
  - A 16-bit wait counter increments each cycle without that transfer. When it reaches pair_timeout: pair_err <= 1 and the FSM returns to FREE.
  - If the requester-1 transfer lands in the same cycle the counter reaches the timeout, the transfer wins and pair_err is not set.
  - If pair_mode falls while in WAIT_R, the FSM returns to FREE on the next cycle with no error.
- Wait counter clears on every entry to WAIT_R.
- stall_cnt increments in every cycle where fifo_full=1 and |req_valid=1. It saturates at 0xFFFF.
- clr_stats has priority over both the stall_cnt increment and pair_err set in the same cycle.
- grant_id updates on every transfer.

## Timing
- Reset values:
  - FSM = FREE, pointer = 0, wait counter = 0.
  - grant_id = 0, stall_cnt = 0, pair_err = 0.
  - While rst=0, req_ready = 0 and fifo_wr_en = 0 regardless of inputs.
- Latency: request to FIFO write is 0 cycles (same wr_clk edge).
- grant_id, stall_cnt and pair_err reflect a transfer one cycle after it.
- fifo_full is sampled combinationally in the cycle it is presented. A write is never issued while fifo_full=1, so the FIFO is never overrun.
- Reset asserted mid-pair: the FSM drops to FREE immediately and the pending pair is discarded without setting pair_err.
- Requesters must hold req_valid and req_data stable until accepted.

## Test plan
- Round-robin: num_req=3, pair_mode=0, all valid continuously, fifo_full=0.
  - Grant order 0,1,2,0,1,2.
  - fifo_wr_en=1 every cycle.
  - fifo_din equals the granted requester's data each cycle.
- Back-pressure: fifo_full=1 for 10 cycles with req_valid=3'b011.
  - fifo_wr_en=0 and req_ready=0 throughout.
  - stall_cnt=10; resumes with a grant in the cycle full falls.
- Pair mode: pair_mode=1, req1 valid first, req0 valid 3 cycles later.
  - req1 is not granted until req0 transfers.
  - Writes occur as 0 then 1; FSM returns to FREE.
  - req2 (num_req=3) is blocked while in WAIT_R.
- Timeout: pair_timeout=8, req0 transfers, req1 stays idle.
  - pair_err=1 after 8 cycles and FSM returns to FREE.
  - clr_stats pulse clears pair_err and stall_cnt to 0.
  - Repeat with the req1 transfer on cycle 8: pair_err stays 0.
- Reset and saturation:
  - rst low while in WAIT_R: all outputs at reset values; first grant after release goes to requester 0.
  - Preload 0xFFFE stall cycles: stall_cnt saturates at 0xFFFF.
